// File: rtl/add_vec_engine.sv
// add_vec_engine: streams NUM_LINES cache lines from SRC_ADDR, adds the low-half
// lanes (A) to the high-half lanes (B) with wrap or unsigned saturation, and writes
// each result line to DST_ADDR. One read outstanding at a time; write completions
// are counted into LINES_DONE.
// Ports:
//   clk, reset_n                         clock, async active-low reset
//   mmio_wr_valid/rd_valid/addr/tid/wr_data   MMIO CSR access (addr in 32-bit words)
//   mmio_rd_rsp_valid/tid/data           MMIO read response, one cycle after the read
//   rd_req_valid/addr, rd_req_almfull    memory read request channel
//   rd_rsp_valid/data                    memory read response
//   wr_req_valid/addr/data, wr_req_almfull    memory write request channel
//   wr_rsp_valid                         one completion per issued write
module add_vec_engine #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LINE_W = 512,
  parameter int unsigned ADDR_W = 42,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mmio_wr_valid,
  input  logic              mmio_rd_valid,
  input  logic [15:0]       mmio_addr,
  input  logic [8:0]        mmio_tid,
  input  logic [63:0]       mmio_wr_data,
  output logic              mmio_rd_rsp_valid,
  output logic [8:0]        mmio_rd_rsp_tid,
  output logic [63:0]       mmio_rd_rsp_data,
  output logic              rd_req_valid,
  output logic [ADDR_W-1:0] rd_req_addr,
  input  logic              rd_req_almfull,
  input  logic              rd_rsp_valid,
  input  logic [LINE_W-1:0] rd_rsp_data,
  output logic              wr_req_valid,
  output logic [ADDR_W-1:0] wr_req_addr,
  output logic [LINE_W-1:0] wr_req_data,
  input  logic              wr_req_almfull,
  input  logic              wr_rsp_valid
);

  localparam int unsigned LANES = LINE_W / (2 * DATA_W);
  localparam logic [15:0] A_SRC    = 16'h0010;
  localparam logic [15:0] A_DST    = 16'h0012;
  localparam logic [15:0] A_NUM    = 16'h0014;
  localparam logic [15:0] A_CTRL   = 16'h0016;
  localparam logic [15:0] A_STATUS = 16'h0018;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_CALC, S_WR_REQ, S_DRAIN, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   src_q, dst_q;
  logic [CNT_W-1:0]    num_q, idx_q, lines_done_q;
  logic                mode_q;
  logic [LINE_W-1:0]   line_q;

  logic                busy_c, done_c, start_c, rd_issue_c, wr_issue_c;
  logic [LINE_W-1:0]   res_c;
  logic [63:0]         rdata_c;
  logic [DATA_W:0]     sum_c;
  logic                unused_c;

  // Upper write-data bits never land in any CSR.
  assign unused_c = ^mmio_wr_data[63:ADDR_W];

  assign busy_c  = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_c  = (state_q == S_DONE);
  assign start_c = mmio_wr_valid && (mmio_addr == A_CTRL) && mmio_wr_data[0] && !busy_c;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state and request-issue decisions.
  always_comb begin
    state_d    = state_q;
    rd_issue_c = 1'b0;
    wr_issue_c = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_c) state_d = (num_q == '0) ? S_DONE : S_RD_REQ;
      end
      S_RD_REQ: begin
        if (!rd_req_almfull) begin
          rd_issue_c = 1'b1;
          state_d    = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (rd_rsp_valid) state_d = S_CALC;
      end
      S_CALC: state_d = S_WR_REQ;
      S_WR_REQ: begin
        if (!wr_req_almfull) begin
          wr_issue_c = 1'b1;
          state_d    = ((idx_q + CNT_W'(1)) < num_q) ? S_RD_REQ : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (lines_done_q == num_q) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Per-lane add; saturation clamps on carry-out, upper half of the result stays zero.
  always_comb begin
    res_c = '0;
    sum_c = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      sum_c = {1'b0, line_q[i*DATA_W +: DATA_W]} + {1'b0, line_q[(int'(LANES)+i)*DATA_W +: DATA_W]};
      res_c[i*DATA_W +: DATA_W] = (mode_q && sum_c[DATA_W]) ? '1 : sum_c[DATA_W-1:0];
    end
  end

  // CSR read mux.
  always_comb begin
    rdata_c = '0;
    case (mmio_addr)
      A_SRC:  rdata_c = 64'(src_q);
      A_DST:  rdata_c = 64'(dst_q);
      A_NUM:  rdata_c = 64'(num_q);
      A_CTRL: rdata_c[1] = mode_q;
      A_STATUS: begin
        rdata_c[0]          = busy_c;
        rdata_c[1]          = done_c;
        rdata_c[32 +: CNT_W] = lines_done_q;
      end
      default: rdata_c = '0;
    endcase
  end

  // CSRs, counters, datapath and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_q             <= '0;
      dst_q             <= '0;
      num_q             <= '0;
      mode_q            <= 1'b0;
      idx_q             <= '0;
      lines_done_q      <= '0;
      line_q            <= '0;
      rd_req_valid      <= 1'b0;
      rd_req_addr       <= '0;
      wr_req_valid      <= 1'b0;
      wr_req_addr       <= '0;
      wr_req_data       <= '0;
      mmio_rd_rsp_valid <= 1'b0;
      mmio_rd_rsp_tid   <= '0;
      mmio_rd_rsp_data  <= '0;
    end else begin
      if (mmio_wr_valid && !busy_c) begin
        case (mmio_addr)
          A_SRC:   src_q  <= mmio_wr_data[ADDR_W-1:0];
          A_DST:   dst_q  <= mmio_wr_data[ADDR_W-1:0];
          A_NUM:   num_q  <= mmio_wr_data[CNT_W-1:0];
          A_CTRL:  mode_q <= mmio_wr_data[1];
          default: ;
        endcase
      end

      // Completions count in every active state; stale ones after reset land in IDLE.
      if (start_c)
        lines_done_q <= '0;
      else if (wr_rsp_valid && (state_q != S_IDLE))
        lines_done_q <= lines_done_q + CNT_W'(1);

      rd_req_valid <= rd_issue_c;
      if (rd_issue_c) rd_req_addr <= src_q + ADDR_W'(idx_q);

      wr_req_valid <= wr_issue_c;
      if (start_c)
        idx_q <= '0;
      else if (wr_issue_c) begin
        wr_req_addr <= dst_q + ADDR_W'(idx_q);
        idx_q       <= idx_q + CNT_W'(1);
      end

      if ((state_q == S_RD_WAIT) && rd_rsp_valid) line_q <= rd_rsp_data;
      if (state_q == S_CALC) wr_req_data <= res_c;

      mmio_rd_rsp_valid <= mmio_rd_valid;
      if (mmio_rd_valid) begin
        mmio_rd_rsp_tid  <= mmio_tid;
        mmio_rd_rsp_data <= rdata_c;
      end
    end
  end

endmodule

// File: tb/tb_add_vec_engine.sv
// Bench for add_vec_engine: memory responder with random latencies, output monitor,
// and a lane-arithmetic reference model used to predict every written line.
module tb_add_vec_engine;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned LINE_W = 512;
  localparam int unsigned ADDR_W = 42;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned LANES  = LINE_W / (2 * DATA_W);
  localparam logic [15:0] A_SRC = 16'h10, A_DST = 16'h12, A_NUM = 16'h14,
                          A_CTRL = 16'h16, A_STATUS = 16'h18;

  logic clk, reset_n;
  logic mmio_wr_valid, mmio_rd_valid;
  logic [15:0] mmio_addr;
  logic [8:0]  mmio_tid;
  logic [63:0] mmio_wr_data;
  logic mmio_rd_rsp_valid;
  logic [8:0]  mmio_rd_rsp_tid;
  logic [63:0] mmio_rd_rsp_data;
  logic rd_req_valid, rd_req_almfull, rd_rsp_valid;
  logic [ADDR_W-1:0] rd_req_addr, wr_req_addr;
  logic [LINE_W-1:0] rd_rsp_data, wr_req_data;
  logic wr_req_valid, wr_req_almfull, wr_rsp_valid;

  add_vec_engine #(.DATA_W(DATA_W), .LINE_W(LINE_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .mmio_wr_valid(mmio_wr_valid), .mmio_rd_valid(mmio_rd_valid), .mmio_addr(mmio_addr),
    .mmio_tid(mmio_tid), .mmio_wr_data(mmio_wr_data),
    .mmio_rd_rsp_valid(mmio_rd_rsp_valid), .mmio_rd_rsp_tid(mmio_rd_rsp_tid),
    .mmio_rd_rsp_data(mmio_rd_rsp_data),
    .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_almfull(rd_req_almfull),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
    .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
    .wr_req_almfull(wr_req_almfull), .wr_rsp_valid(wr_rsp_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  logic [ADDR_W-1:0] rd_log[$];
  logic [ADDR_W-1:0] wr_addr_log[$];
  logic [LINE_W-1:0] wr_data_log[$];
  logic [LINE_W-1:0] served[$];
  logic [LINE_W-1:0] line_src[$];
  int both_seen = 0;
  int wr_rsp_count = 0;
  bit mem_auto = 1'b1;
  bit stale_rd = 1'b0, stale_wr = 1'b0;
  bit rand_af = 1'b0, force_wr_af = 1'b0;
  int rd_cnt = 0;
  logic [LINE_W-1:0] rd_pending;
  int wr_due[$];

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] l;
    for (int j = 0; j < int'(LINE_W / 32); j++) l[j*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [LINE_W-1:0] fill_line(logic [7:0] a, logic [7:0] b);
    logic [LINE_W-1:0] l;
    for (int i = 0; i < int'(LANES); i++) begin
      l[i*8 +: 8]           = a;
      l[(LANES+i)*8 +: 8]   = b;
    end
    return l;
  endfunction

  // Reference: lane sums in integer arithmetic, clamp or reduce modulo 2^DATA_W.
  function automatic logic [LINE_W-1:0] exp_line(logic [LINE_W-1:0] src, bit mode);
    logic [LINE_W-1:0] r;
    longint unsigned a, b, s, top;
    r   = '0;
    top = (longint'(1) << DATA_W);
    for (int i = 0; i < int'(LANES); i++) begin
      a = longint'(src[i*DATA_W +: DATA_W]);
      b = longint'(src[(LANES+i)*DATA_W +: DATA_W]);
      s = a + b;
      if (mode && s >= top) s = top - 1;
      else s = s % top;
      r[i*DATA_W +: DATA_W] = DATA_W'(s);
    end
    return r;
  endfunction

  // Memory model: random read latency, random per-write completion delay.
  always @(negedge clk) begin
    rd_rsp_valid   = 1'b0;
    wr_rsp_valid   = 1'b0;
    rd_req_almfull = rand_af && ($urandom_range(0, 3) == 0);
    wr_req_almfull = force_wr_af || (rand_af && ($urandom_range(0, 3) == 0));
    if (!reset_n) begin
      rd_cnt = 0;
      wr_due.delete();
    end else begin
      if (stale_rd) begin rd_rsp_valid = 1'b1; rd_rsp_data = rand_line(); stale_rd = 1'b0; end
      if (stale_wr) begin wr_rsp_valid = 1'b1; stale_wr = 1'b0; end
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin rd_rsp_valid = 1'b1; rd_rsp_data = rd_pending; end
      end
      foreach (wr_due[k]) if (wr_due[k] > 0) wr_due[k]--;
      if (wr_due.size() > 0 && wr_due[0] == 0) begin
        void'(wr_due.pop_front());
        wr_rsp_valid = 1'b1;
        wr_rsp_count++;
      end
      if (rd_req_valid && mem_auto) begin
        rd_pending = (line_src.size() > 0) ? line_src.pop_front() : rand_line();
        served.push_back(rd_pending);
        rd_cnt = $urandom_range(1, 3);
      end
      if (wr_req_valid) wr_due.push_back($urandom_range(0, 4));
    end
  end

  // Output monitor.
  always @(negedge clk) begin
    if (rd_req_valid) rd_log.push_back(rd_req_addr);
    if (wr_req_valid) begin
      wr_addr_log.push_back(wr_req_addr);
      wr_data_log.push_back(wr_req_data);
    end
    if (rd_req_valid && wr_req_valid) both_seen++;
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mmio_write(logic [15:0] a, logic [63:0] d);
    mmio_wr_valid = 1'b1; mmio_addr = a; mmio_wr_data = d;
    tick();
    mmio_wr_valid = 1'b0;
  endtask

  task automatic mmio_read(logic [15:0] a, logic [8:0] tid,
                           output logic v, output logic [8:0] t, output logic [63:0] d);
    mmio_rd_valid = 1'b1; mmio_addr = a; mmio_tid = tid;
    tick();
    mmio_rd_valid = 1'b0;
    v = mmio_rd_rsp_valid; t = mmio_rd_rsp_tid; d = mmio_rd_rsp_data;
  endtask

  task automatic clear_logs();
    rd_log.delete(); wr_addr_log.delete(); wr_data_log.delete(); served.delete();
    wr_rsp_count = 0;
  endtask

  task automatic poll_done(output bit timeout, output logic [63:0] st);
    logic v; logic [8:0] t;
    timeout = 1'b1;
    st = '0;
    for (int n = 0; n < 400; n++) begin
      mmio_read(A_STATUS, 9'(n), v, t, st);
      if (st[1]) begin timeout = 1'b0; break; end
    end
  endtask

  task automatic run_op(logic [ADDR_W-1:0] src, logic [ADDR_W-1:0] dst, int num, bit mode,
                        output bit timeout, output logic [63:0] st);
    clear_logs();
    mmio_write(A_SRC, 64'(src));
    mmio_write(A_DST, 64'(dst));
    mmio_write(A_NUM, 64'(num));
    mmio_write(A_CTRL, 64'({mode, 1'b1}));
    poll_done(timeout, st);
  endtask

  task automatic test_reset();
    logic v; logic [8:0] t; logic [63:0] d;
    logic [15:0] addrs[5];
    addrs = '{A_SRC, A_DST, A_NUM, A_CTRL, A_STATUS};
    tests_run++;
    if ({rd_req_valid, wr_req_valid, mmio_rd_rsp_valid} !== 3'b000) begin
      tests_failed++; $display("FAIL reset_valids: got %b expected 000", {rd_req_valid, wr_req_valid, mmio_rd_rsp_valid});
    end
    foreach (addrs[k]) begin
      mmio_read(addrs[k], 9'(k + 1), v, t, d);
      tests_run++;
      if (v !== 1'b1 || t !== 9'(k + 1) || d !== 64'd0) begin
        tests_failed++; $display("FAIL reset_csr_%0h: got v=%b tid=%0d d=%0h expected v=1 tid=%0d d=0", addrs[k], v, t, d, k + 1);
      end
    end
  endtask

  task automatic test_csr();
    logic v; logic [8:0] t; logic [63:0] d;
    logic [ADDR_W-1:0] s;
    s = ADDR_W'({$urandom, $urandom});
    mmio_write(A_SRC, {22'h3FFFFF, s});
    mmio_read(A_SRC, 9'h1AB, v, t, d);
    tests_run++;
    if (v !== 1'b1 || t !== 9'h1AB || d !== 64'(s)) begin
      tests_failed++; $display("FAIL csr_src: got v=%b tid=%0h d=%0h expected v=1 tid=1ab d=%0h", v, t, d, 64'(s));
    end
    tick();
    tests_run++;
    if (mmio_rd_rsp_valid !== 1'b0) begin
      tests_failed++; $display("FAIL csr_rsp_one_cycle: got %b expected 0", mmio_rd_rsp_valid);
    end
    mmio_write(A_CTRL, 64'h2);
    mmio_read(A_CTRL, 9'h2, v, t, d);
    tests_run++;
    if (d !== 64'h2) begin
      tests_failed++; $display("FAIL csr_ctrl_mode: got %0h expected 2", d);
    end
    mmio_write(16'h0020, 64'hDEAD);
    mmio_read(16'h0020, 9'h3, v, t, d);
    tests_run++;
    if (v !== 1'b1 || d !== 64'h0) begin
      tests_failed++; $display("FAIL csr_unmapped: got v=%b d=%0h expected v=1 d=0", v, d);
    end
  endtask

  task automatic test_single_line();
    bit to; logic [63:0] st;
    line_src.push_back(fill_line(8'h05, 8'h07));
    run_op(ADDR_W'(64'h1000), ADDR_W'(64'h2000), 1, 1'b0, to, st);
    tests_run++;
    if (to || wr_addr_log.size() != 1 || wr_addr_log[0] !== ADDR_W'(64'h2000)) begin
      tests_failed++; $display("FAIL single_write: got timeout=%0d writes=%0d addr=%0h expected 0/1/2000", to, wr_addr_log.size(), wr_addr_log[0]);
    end
    tests_run++;
    if (wr_data_log[0] !== exp_line(fill_line(8'h05, 8'h07), 1'b0) || wr_data_log[0][7:0] !== 8'h0C
        || wr_data_log[0][LINE_W-1:LINE_W/2] !== '0) begin
      tests_failed++; $display("FAIL single_data: got lane0=%0h upper_nonzero=%0d expected 0c/0", wr_data_log[0][7:0], |wr_data_log[0][LINE_W-1:LINE_W/2]);
    end
    tests_run++;
    if (st !== 64'h1_0000_0002) begin
      tests_failed++; $display("FAIL single_status: got %0h expected 100000002", st);
    end
  endtask

  task automatic test_saturate();
    bit to; logic [63:0] st;
    logic [7:0] want[2];
    want = '{8'hFF, 8'h10};
    for (int m = 0; m < 2; m++) begin
      line_src.push_back(fill_line(8'hF0, 8'h20));
      run_op(ADDR_W'(64'h300), ADDR_W'(64'h400), 1, m == 0, to, st);
      tests_run++;
      if (to || wr_data_log.size() != 1 || wr_data_log[0] !== exp_line(fill_line(8'hF0, 8'h20), m == 0)
          || wr_data_log[0][8*(LANES-1) +: 8] !== want[m]) begin
        tests_failed++; $display("FAIL saturate_mode%0d: got lane=%0h writes=%0d expected %0h/1", 1 - m, wr_data_log[0][8*(LANES-1) +: 8], wr_data_log.size(), want[m]);
      end
    end
  endtask

  task automatic test_multi_line();
    bit to; logic [63:0] st;
    run_op(ADDR_W'(64'h100), ADDR_W'(64'h200), 3, 1'b1, to, st);
    tests_run++;
    if (to || rd_log.size() != 3 || wr_addr_log.size() != 3) begin
      tests_failed++; $display("FAIL multi_counts: got timeout=%0d reads=%0d writes=%0d expected 0/3/3", to, rd_log.size(), wr_addr_log.size());
    end
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (rd_log[k] !== ADDR_W'(64'h100 + k) || wr_addr_log[k] !== ADDR_W'(64'h200 + k)
          || wr_data_log[k] !== exp_line(served[k], 1'b1)) begin
        tests_failed++; $display("FAIL multi_line%0d: got rd=%0h wr=%0h expected rd=%0h wr=%0h (data checked too)", k, rd_log[k], wr_addr_log[k], 64'h100 + k, 64'h200 + k);
      end
    end
    tests_run++;
    if (wr_rsp_count != 3 || st !== 64'h3_0000_0002) begin
      tests_failed++; $display("FAIL multi_done: got rsps=%0d status=%0h expected 3/300000002", wr_rsp_count, st);
    end
  endtask

  task automatic test_random();
    bit to; logic [63:0] st; int num; bit mode;
    logic [ADDR_W-1:0] src, dst;
    rand_af = 1'b1;
    for (int it = 0; it < 5; it++) begin
      num  = $urandom_range(1, 6);
      mode = 1'($urandom_range(0, 1));
      src  = (it == 0) ? ADDR_W'({ADDR_W{1'b1}} - 1) : ADDR_W'({$urandom, $urandom});
      dst  = (it == 0) ? ADDR_W'({ADDR_W{1'b1}}) : ADDR_W'({$urandom, $urandom});
      run_op(src, dst, num, mode, to, st);
      tests_run++;
      if (to || rd_log.size() != num || wr_addr_log.size() != num || st[32 +: CNT_W] !== CNT_W'(num)) begin
        tests_failed++; $display("FAIL rand%0d_counts: got timeout=%0d reads=%0d writes=%0d done=%0d expected %0d", it, to, rd_log.size(), wr_addr_log.size(), st[32 +: CNT_W], num);
      end
      for (int k = 0; k < num; k++) begin
        tests_run++;
        if (rd_log[k] !== src + ADDR_W'(k) || wr_addr_log[k] !== dst + ADDR_W'(k)
            || wr_data_log[k] !== exp_line(served[k], mode)) begin
          tests_failed++; $display("FAIL rand%0d_line%0d: got rd=%0h wr=%0h expected rd=%0h wr=%0h mode=%0d", it, k, rd_log[k], wr_addr_log[k], src + ADDR_W'(k), dst + ADDR_W'(k), mode);
        end
      end
    end
    rand_af = 1'b0;
  endtask

  task automatic test_almfull();
    bit to; logic [63:0] st; int n;
    clear_logs();
    force_wr_af = 1'b1;
    mmio_write(A_SRC, 64'h500);
    mmio_write(A_DST, 64'h600);
    mmio_write(A_NUM, 64'h1);
    mmio_write(A_CTRL, 64'h1);
    n = 0;
    while (served.size() == 0 && n < 50) begin tick(); n++; end
    tick(4);
    tick(10);
    tests_run++;
    if (served.size() != 1 || wr_addr_log.size() != 0) begin
      tests_failed++; $display("FAIL almfull_hold: got reads=%0d writes=%0d expected 1/0", served.size(), wr_addr_log.size());
    end
    force_wr_af = 1'b0;
    tick();
    tests_run++;
    if (wr_req_valid !== 1'b1 || wr_req_addr !== ADDR_W'(64'h600)) begin
      tests_failed++; $display("FAIL almfull_release: got valid=%b addr=%0h expected 1/600", wr_req_valid, wr_req_addr);
    end
    poll_done(to, st);
    tests_run++;
    if (to || wr_data_log.size() != 1 || wr_data_log[0] !== exp_line(served[0], 1'b0)) begin
      tests_failed++; $display("FAIL almfull_data: got timeout=%0d writes=%0d expected 0/1", to, wr_data_log.size());
    end
  endtask

  task automatic test_zero_lines();
    logic v; logic [8:0] t; logic [63:0] d;
    clear_logs();
    mmio_write(A_NUM, 64'h0);
    mmio_write(A_CTRL, 64'h1);
    mmio_read(A_STATUS, 9'h7, v, t, d);
    tests_run++;
    if (d !== 64'h2) begin
      tests_failed++; $display("FAIL zero_status: got %0h expected 2", d);
    end
    tick(5);
    tests_run++;
    if (rd_log.size() != 0 || wr_addr_log.size() != 0) begin
      tests_failed++; $display("FAIL zero_requests: got reads=%0d writes=%0d expected 0/0", rd_log.size(), wr_addr_log.size());
    end
  endtask

  task automatic test_busy_ignore();
    bit to; logic [63:0] st; logic v; logic [8:0] t; logic [63:0] d;
    clear_logs();
    mmio_write(A_SRC, 64'h40);
    mmio_write(A_DST, 64'h80);
    mmio_write(A_NUM, 64'h4);
    mmio_write(A_CTRL, 64'h1);
    mmio_write(A_SRC, 64'h999);
    mmio_write(A_NUM, 64'h1);
    mmio_write(A_CTRL, 64'h3);
    poll_done(to, st);
    mmio_read(A_SRC, 9'h10, v, t, d);
    tests_run++;
    if (to || d !== 64'h40 || wr_addr_log.size() != 4) begin
      tests_failed++; $display("FAIL busy_ignore: got timeout=%0d src=%0h writes=%0d expected 0/40/4", to, d, wr_addr_log.size());
    end
    tests_run++;
    if (wr_data_log[3] !== exp_line(served[3], 1'b0)) begin
      tests_failed++; $display("FAIL busy_mode: got lane0=%0h expected %0h", wr_data_log[3][7:0], exp_line(served[3], 1'b0) & 8'hFF);
    end
    clear_logs();
    mmio_write(A_CTRL, 64'h1);
    poll_done(to, st);
    tests_run++;
    if (to || wr_addr_log.size() != 4 || wr_addr_log[3] !== ADDR_W'(64'h83) || st !== 64'h4_0000_0002) begin
      tests_failed++; $display("FAIL restart_from_done: got timeout=%0d writes=%0d status=%0h expected 0/4/400000002", to, wr_addr_log.size(), st);
    end
  endtask

  task automatic test_reset_mid();
    bit to; logic [63:0] st; logic v; logic [8:0] t; logic [63:0] d; int n;
    clear_logs();
    mem_auto = 1'b0;
    mmio_write(A_SRC, 64'h700);
    mmio_write(A_DST, 64'h800);
    mmio_write(A_NUM, 64'h2);
    mmio_write(A_CTRL, 64'h1);
    n = 0;
    while (rd_log.size() == 0 && n < 50) begin tick(); n++; end
    tick(2);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    mem_auto = 1'b1;
    stale_rd = 1'b1;
    stale_wr = 1'b1;
    tick(4);
    mmio_read(A_STATUS, 9'h11, v, t, d);
    tests_run++;
    if (d !== 64'h0 || rd_log.size() != 1 || wr_addr_log.size() != 0) begin
      tests_failed++; $display("FAIL reset_mid_idle: got status=%0h reads=%0d writes=%0d expected 0/1/0", d, rd_log.size(), wr_addr_log.size());
    end
    mmio_read(A_NUM, 9'h12, v, t, d);
    tests_run++;
    if (d !== 64'h0) begin
      tests_failed++; $display("FAIL reset_mid_csr: got %0h expected 0", d);
    end
    run_op(ADDR_W'(64'h700), ADDR_W'(64'h800), 2, 1'b0, to, st);
    tests_run++;
    if (to || wr_addr_log.size() != 2 || wr_addr_log[1] !== ADDR_W'(64'h801)
        || wr_data_log[1] !== exp_line(served[1], 1'b0) || st !== 64'h2_0000_0002) begin
      tests_failed++; $display("FAIL reset_mid_restart: got timeout=%0d writes=%0d status=%0h expected 0/2/200000002", to, wr_addr_log.size(), st);
    end
  endtask

  task automatic test_exclusive();
    tests_run++;
    if (both_seen != 0) begin
      tests_failed++; $display("FAIL rd_wr_exclusive: got %0d overlapping cycles expected 0", both_seen);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    mmio_wr_valid = 1'b0; mmio_rd_valid = 1'b0;
    mmio_addr = '0; mmio_tid = '0; mmio_wr_data = '0;
    rd_req_almfull = 1'b0; wr_req_almfull = 1'b0;
    rd_rsp_valid = 1'b0; rd_rsp_data = '0; wr_rsp_valid = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick();
    test_reset();
    test_csr();
    test_single_line();
    test_saturate();
    test_multi_line();
    test_random();
    test_almfull();
    test_zero_lines();
    test_busy_ignore();
    test_reset_mid();
    test_exclusive();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
